// File: rtl/disp_pkg.sv
// Shared types and timing-count helpers for the ultrasonic ranger display controller.
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_e;

  typedef logic [3:0] bcd_t;

  // Cycles per half period of a square wave at out_hz.
  function automatic int scan_div_count(input int clk_hz, input int scan_hz);
    return int'(longint'(clk_hz) / (2 * longint'(scan_hz)));
  endfunction

  function automatic int blink_count(input int clk_hz, input int blink_hz);
    return int'(longint'(clk_hz) / (2 * longint'(blink_hz)));
  endfunction

  // Widened so that ms * clk_hz cannot overflow 32 bits at high clock rates.
  function automatic int timeout_count(input int clk_hz, input int timeout_ms);
    return int'(longint'(timeout_ms) * longint'(clk_hz) / 64'sd1000);
  endfunction

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Serial shift-add-3 binary to 4-digit BCD converter; one input bit per cycle.
module bin2bcd_seq
  import disp_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [DATA_W-1:0] bin_i,
  output logic              done_o,
  output bcd_t              bcd3_o,
  output bcd_t              bcd2_o,
  output bcd_t              bcd1_o,
  output bcd_t              bcd0_o
);

  localparam int CW = cnt_width(DATA_W);

  logic [DATA_W-1:0] bin_q, bin_d;
  logic [15:0]       bcd_q, bcd_d, adj;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              run_q, run_d;
  logic              done_q, done_d;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Digits above the thousands are discarded; over-range values are replaced upstream.
  always_comb begin
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = 1'b0;
    if (start_i) begin
      bin_d = bin_i;
      bcd_d = '0;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      bcd_d = {adj[14:0], bin_q[DATA_W-1]};
      bin_d = bin_q << 1;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(DATA_W-1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    bin_q <= bin_d;
    bcd_q <= bcd_d;
  end

  assign done_o = done_q;
  assign bcd3_o = bcd_q[15:12];
  assign bcd2_o = bcd_q[11:8];
  assign bcd1_o = bcd_q[7:4];
  assign bcd0_o = bcd_q[3:0];

endmodule

// File: rtl/sonic_disp_ctrl.sv
// Display sequencer for the ultrasonic ranger: BCD conversion with a 1-deep pending slot,
// atomic digit load, scan clock, blink and stale-data blanking.
module sonic_disp_ctrl
  import disp_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int SCAN_HZ    = 500,
  parameter int DATA_W     = 16,
  parameter int MAX_VAL    = 9999,
  parameter int TIMEOUT_MS = 1000,
  parameter int BLINK_HZ   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              dist_valid,
  input  logic [DATA_W-1:0] dist_data,
  output logic              busy,
  output logic              overflow,
  output bcd_t              num3,
  output bcd_t              num2,
  output bcd_t              num1,
  output bcd_t              num0,
  output logic              dig_show,
  output logic              clk_500
);

  localparam int DIV_N   = scan_div_count(CLK_HZ, SCAN_HZ);
  localparam int DIV_W   = cnt_width(DIV_N);
  localparam int BLINK_N = blink_count(CLK_HZ, BLINK_HZ);
  localparam int BLINK_W = cnt_width(BLINK_N);
  localparam int TO_N    = timeout_count(CLK_HZ, TIMEOUT_MS);
  localparam int TO_W    = cnt_width(TO_N);
  localparam logic [DATA_W:0] MAX_V = (DATA_W+1)'(MAX_VAL);

  state_e            state_q, state_d;
  logic              pend_vld_q, pend_vld_d;
  logic [DATA_W-1:0] pend_data_q, pend_data_d;
  logic              cur_ovf_q, cur_ovf_d;
  logic              start;
  logic [DATA_W-1:0] start_val;
  logic              conv_done;
  bcd_t              b3, b2, b1, b0;
  bcd_t              num3_q, num2_q, num1_q, num0_q;
  bcd_t              num3_d, num2_d, num1_d, num0_d;
  logic              overflow_q, overflow_d;
  logic              busy_q, dig_show_q, dig_show_d;
  logic              fresh_q, fresh_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              blink_q, blink_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              clk500_q, clk500_d;

  bin2bcd_seq #(.DATA_W(DATA_W)) u_bcd (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(start),
    .bin_i  (start_val),
    .done_o (conv_done),
    .bcd3_o (b3),
    .bcd2_o (b2),
    .bcd1_o (b1),
    .bcd0_o (b0)
  );

  always_comb begin
    state_d     = state_q;
    pend_vld_d  = pend_vld_q;
    pend_data_d = pend_data_q;
    cur_ovf_d   = cur_ovf_q;
    start       = 1'b0;
    start_val   = dist_data;
    num3_d      = num3_q;
    num2_d      = num2_q;
    num1_d      = num1_q;
    num0_d      = num0_q;
    overflow_d  = overflow_q;
    case (state_q)
      IDLE: begin
        if (dist_valid) begin
          start   = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        if (dist_valid) begin
          pend_vld_d  = 1'b1;
          pend_data_d = dist_data;
        end
        if (conv_done) state_d = LOAD;
      end
      LOAD: begin
        overflow_d = cur_ovf_q;
        if (cur_ovf_q) begin
          {num3_d, num2_d, num1_d, num0_d} = {4{4'd9}};
        end else begin
          {num3_d, num2_d, num1_d, num0_d} = {b3, b2, b1, b0};
        end
        // A strobe landing in this cycle is newer than anything already pending.
        if (pend_vld_q || dist_valid) begin
          start      = 1'b1;
          start_val  = dist_valid ? dist_data : pend_data_q;
          pend_vld_d = 1'b0;
          state_d    = CONV;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (start) cur_ovf_d = ({1'b0, start_val} > MAX_V);
  end

  always_comb begin
    fresh_d     = fresh_q;
    to_d        = to_q;
    blink_d     = blink_q;
    blink_cnt_d = blink_cnt_q + 1'b1;
    div_d       = div_q + 1'b1;
    clk500_d    = clk500_q;
    if (state_q == LOAD) begin
      fresh_d = 1'b1;
      to_d    = '0;
    end else if (fresh_q) begin
      if (to_q == TO_W'(TO_N-1)) begin
        fresh_d = 1'b0;
        to_d    = '0;
      end else begin
        to_d = to_q + 1'b1;
      end
    end
    if (blink_cnt_q == BLINK_W'(BLINK_N-1)) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end
    if (div_q == DIV_W'(DIV_N-1)) begin
      div_d    = '0;
      clk500_d = ~clk500_q;
    end
    dig_show_d = enable & fresh_d & (~overflow_d | blink_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pend_vld_q  <= 1'b0;
      cur_ovf_q   <= 1'b0;
      num3_q      <= '0;
      num2_q      <= '0;
      num1_q      <= '0;
      num0_q      <= '0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
      dig_show_q  <= 1'b0;
      fresh_q     <= 1'b0;
      to_q        <= '0;
      blink_q     <= 1'b1;
      blink_cnt_q <= '0;
      div_q       <= '0;
      clk500_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_vld_q  <= pend_vld_d;
      cur_ovf_q   <= cur_ovf_d;
      num3_q      <= num3_d;
      num2_q      <= num2_d;
      num1_q      <= num1_d;
      num0_q      <= num0_d;
      overflow_q  <= overflow_d;
      busy_q      <= (state_d != IDLE);
      dig_show_q  <= dig_show_d;
      fresh_q     <= fresh_d;
      to_q        <= to_d;
      blink_q     <= blink_d;
      blink_cnt_q <= blink_cnt_d;
      div_q       <= div_d;
      clk500_q    <= clk500_d;
    end
  end

  always_ff @(posedge clk) begin
    pend_data_q <= pend_data_d;
  end

  assign busy     = busy_q;
  assign overflow = overflow_q;
  assign num3     = num3_q;
  assign num2     = num2_q;
  assign num1     = num1_q;
  assign num0     = num0_q;
  assign dig_show = dig_show_q;
  assign clk_500  = clk500_q;

endmodule

// File: tb/tb_sonic_disp_ctrl.sv
// Self-checking bench for sonic_disp_ctrl at a scaled-down clock rate.
module tb_sonic_disp_ctrl;
  import disp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        dist_valid;
  logic [15:0] dist_data;
  logic        busy, overflow, dig_show, clk_500;
  bcd_t        num3, num2, num1, num0;

  int total = 0;
  int bad   = 0;
  logic [15:0] model_num = 16'h0000;

  always #5 clk = ~clk;

  sonic_disp_ctrl #(
    .CLK_HZ(10_000), .SCAN_HZ(500), .DATA_W(16), .MAX_VAL(9999),
    .TIMEOUT_MS(100), .BLINK_HZ(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .dist_valid(dist_valid),
    .dist_data(dist_data), .busy(busy), .overflow(overflow),
    .num3(num3), .num2(num2), .num1(num1), .num0(num0),
    .dig_show(dig_show), .clk_500(clk_500)
  );

  function automatic logic [15:0] exp_digits(input int v);
    int d;
    d = (v > 9999) ? 9999 : v;
    return {4'(d / 1000 % 10), 4'(d / 100 % 10), 4'(d / 10 % 10), 4'(d % 10)};
  endfunction

  function automatic logic [15:0] shown();
    return {num3, num2, num1, num0};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Strobe v, check digits still old one edge before the 18-edge latency, then the new load.
  task automatic do_sample(input int v);
    logic [15:0] exp_now;
    logic        exp_ovf;
    exp_now    = exp_digits(v);
    exp_ovf    = (v > 9999);
    dist_data  = 16'(v);
    dist_valid = 1'b1;
    tick;
    dist_valid = 1'b0;
    repeat (17) tick;
    total++;
    if (shown() !== model_num) begin
      bad++; $display("FAIL early_load v=%0d got=%h want=%h", v, shown(), model_num);
    end
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL busy_conv got=%b want=1", busy); end
    tick;
    total++;
    if (shown() !== exp_now) begin
      bad++; $display("FAIL digits v=%0d got=%h want=%h", v, shown(), exp_now);
    end
    total++;
    if (overflow !== exp_ovf) begin
      bad++; $display("FAIL overflow v=%0d got=%b want=%b", v, overflow, exp_ovf);
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL busy_idle got=%b want=0", busy); end
    if (!exp_ovf) begin
      total++;
      if (dig_show !== 1'b1) begin bad++; $display("FAIL dig_show_load v=%0d got=%b want=1", v, dig_show); end
    end
    model_num = exp_now;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) tick;
    total++;
    if ({busy, overflow, dig_show, clk_500} !== 4'b0000) begin
      bad++; $display("FAIL reset_ctrl got=%b want=0000", {busy, overflow, dig_show, clk_500});
    end
    total++;
    if (shown() !== 16'h0000) begin bad++; $display("FAIL reset_num got=%h want=0000", shown()); end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_clk500;
    int   rises[$];
    int   high;
    logic prev;
    prev = clk_500;
    high = 0;
    for (int c = 0; c < 200 && rises.size() < 2; c++) begin
      tick;
      if (clk_500 && !prev) rises.push_back(c);
      if (rises.size() == 1 && clk_500) high++;
      prev = clk_500;
    end
    total++;
    if (rises.size() != 2) begin
      bad++; $display("FAIL clk500_edges got=%0d want=2", rises.size());
    end else begin
      total++;
      if (rises[1] - rises[0] != 20) begin
        bad++; $display("FAIL clk500_period got=%0d want=20", rises[1] - rises[0]);
      end
      total++;
      if (high != 10) begin bad++; $display("FAIL clk500_high got=%0d want=10", high); end
    end
  endtask

  task automatic test_basic;
    do_sample(1234);
  endtask

  task automatic test_zero_max;
    do_sample(0);
    do_sample(9999);
  endtask

  task automatic test_random;
    int v;
    for (int i = 0; i < 8; i++) begin
      v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10000, 65535))
                                      : int'($urandom_range(0, 9999));
      do_sample(v);
    end
  endtask

  task automatic test_blink;
    int   ivals[$];
    int   last_t;
    int   steady_bad;
    logic prev;
    do_sample(10000);
    prev   = dig_show;
    last_t = -1;
    // Periodic re-strobes keep the data fresh so blinking is observable past the timeout.
    for (int cyc = 0; cyc < 9000; cyc++) begin
      dist_valid = (cyc % 500 == 0) && (cyc > 0);
      dist_data  = 16'd10000;
      tick;
      if (dig_show !== prev) begin
        if (last_t >= 0) ivals.push_back(cyc - last_t);
        last_t = cyc;
        prev   = dig_show;
      end
    end
    dist_valid = 1'b0;
    total++;
    if (ivals.size() < 2) begin
      bad++; $display("FAIL blink_count got=%0d want>=2", ivals.size());
    end
    foreach (ivals[k]) begin
      total++;
      if (ivals[k] != 2500) begin bad++; $display("FAIL blink_interval got=%0d want=2500", ivals[k]); end
    end
    total++;
    if (overflow !== 1'b1) begin bad++; $display("FAIL blink_ovf got=%b want=1", overflow); end
    do_sample(42);
    steady_bad = 0;
    for (int cyc = 0; cyc < 900; cyc++) begin
      tick;
      if (dig_show !== 1'b1) steady_bad++;
    end
    total++;
    if (steady_bad != 0) begin bad++; $display("FAIL steady_show got=%0d low cycles want=0", steady_bad); end
  endtask

  task automatic test_stale;
    do_sample(777);
    repeat (990) tick;
    total++;
    if (dig_show !== 1'b1) begin bad++; $display("FAIL pre_stale got=%b want=1", dig_show); end
    repeat (20) tick;
    total++;
    if (dig_show !== 1'b0) begin bad++; $display("FAIL stale_blank got=%b want=0", dig_show); end
    total++;
    if (shown() !== exp_digits(777)) begin bad++; $display("FAIL stale_hold got=%h want=%h", shown(), exp_digits(777)); end
    do_sample(321);
    enable = 1'b0;
    repeat (2) tick;
    total++;
    if (dig_show !== 1'b0) begin bad++; $display("FAIL enable_off got=%b want=0", dig_show); end
    enable = 1'b1;
    tick;
    total++;
    if (dig_show !== 1'b1) begin bad++; $display("FAIL enable_on got=%b want=1", dig_show); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] seen[$];
    logic [15:0] prev;
    int          vals[3];
    vals = '{100, 200, 300};
    foreach (vals[k]) begin
      dist_data  = 16'(vals[k]);
      dist_valid = 1'b1;
      tick;
    end
    dist_valid = 1'b0;
    prev = model_num;
    for (int c = 0; c < 60; c++) begin
      tick;
      if (shown() !== prev) begin seen.push_back(shown()); prev = shown(); end
    end
    total++;
    if (seen.size() != 2) begin
      bad++; $display("FAIL b2b_loads got=%0d want=2", seen.size());
    end else begin
      total++;
      if (seen[0] !== exp_digits(100)) begin bad++; $display("FAIL b2b_first got=%h want=%h", seen[0], exp_digits(100)); end
      total++;
      if (seen[1] !== exp_digits(300)) begin bad++; $display("FAIL b2b_second got=%h want=%h", seen[1], exp_digits(300)); end
    end
    // Strobe arriving exactly in the load cycle.
    dist_data = 16'd500; dist_valid = 1'b1;
    tick;
    dist_valid = 1'b0;
    repeat (17) tick;
    dist_data = 16'd600; dist_valid = 1'b1;
    tick;
    dist_valid = 1'b0;
    total++;
    if (shown() !== exp_digits(500)) begin bad++; $display("FAIL loadcyc_first got=%h want=%h", shown(), exp_digits(500)); end
    repeat (18) tick;
    total++;
    if (shown() !== exp_digits(600)) begin bad++; $display("FAIL loadcyc_second got=%h want=%h", shown(), exp_digits(600)); end
    model_num = exp_digits(600);
  endtask

  task automatic test_reset_mid;
    dist_data = 16'd555; dist_valid = 1'b1;
    tick;
    dist_valid = 1'b0;
    repeat (5) tick;
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, overflow, dig_show, clk_500} !== 4'b0000) begin
      bad++; $display("FAIL midreset_ctrl got=%b want=0000", {busy, overflow, dig_show, clk_500});
    end
    total++;
    if (shown() !== 16'h0000) begin bad++; $display("FAIL midreset_num got=%h want=0000", shown()); end
    repeat (2) tick;
    rst_n = 1'b1;
    repeat (30) tick;
    total++;
    if (shown() !== 16'h0000 || busy !== 1'b0) begin
      bad++; $display("FAIL no_load_after_reset got=%h busy=%b want=0000 busy=0", shown(), busy);
    end
    model_num = 16'h0000;
  endtask

  initial begin
    rst_n      = 1'b0;
    enable     = 1'b1;
    dist_valid = 1'b0;
    dist_data  = '0;
    test_reset;
    test_clk500;
    test_basic;
    test_zero_max;
    test_random;
    test_blink;
    test_stale;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
